// File: rtl/tag_free_list.sv
// Circular free list of the 32 five-bit rename tags.
// Dispatch pops the head tag (first-word-fall-through), commit pushes retired
// tags back, and flush restores the full tag set. Overflow and underflow
// attempts are recorded in sticky error flags that only reset clears.
module tag_free_list (
  input  logic       clock,
  input  logic       reset,
  input  logic       pop_fl,
  output logic [4:0] tag_fl,
  output logic       tag_valid_fl,
  input  logic       push_fl,
  input  logic [4:0] tag_in_fl,
  input  logic       flush_fl,
  output logic [5:0] count_fl,
  output logic       full_fl,
  output logic       empty_fl,
  output logic       ovf_err_fl,
  output logic       unf_err_fl
);

  localparam logic [5:0] DEPTH = 6'd32;

  // Reset/flush image of the storage: slot i holds tag i.
  function automatic logic [31:0][4:0] init_image();
    logic [31:0][4:0] img;
    for (int i = 0; i < 32; i++) begin
      img[i] = 5'(i);
    end
    return img;
  endfunction

  logic [31:0][4:0] mem_r;
  logic [4:0]       head_r;
  logic [4:0]       tail_r;
  logic [5:0]       count_r;
  logic             ovf_r;
  logic             unf_r;

  logic             full_s;
  logic             empty_s;
  logic             pop_ok_s;
  logic             push_ok_s;
  logic             pop_bad_s;
  logic             push_bad_s;
  logic [4:0]       head_nxt_s;
  logic [4:0]       tail_nxt_s;
  logic [5:0]       count_nxt_s;

  // Qualify push/pop against the occupancy seen at the start of the cycle;
  // flush suppresses both requests and their error reporting.
  always_comb begin
    full_s     = (count_r == DEPTH);
    empty_s    = (count_r == 6'd0);
    pop_ok_s   = 1'b0;
    push_ok_s  = 1'b0;
    pop_bad_s  = 1'b0;
    push_bad_s = 1'b0;
    if (!flush_fl) begin
      pop_ok_s   = pop_fl & ~empty_s;
      pop_bad_s  = pop_fl & empty_s;
      push_ok_s  = push_fl & ~full_s;
      push_bad_s = push_fl & full_s;
    end else begin
      pop_ok_s   = 1'b0;
      pop_bad_s  = 1'b0;
      push_ok_s  = 1'b0;
      push_bad_s = 1'b0;
    end
  end

  // Next head, tail and count; pointers wrap through natural 5-bit overflow.
  always_comb begin
    head_nxt_s  = head_r;
    tail_nxt_s  = tail_r;
    count_nxt_s = count_r;
    if (pop_ok_s) begin
      head_nxt_s = head_r + 5'd1;
    end else begin
      head_nxt_s = head_r;
    end
    if (push_ok_s) begin
      tail_nxt_s = tail_r + 5'd1;
    end else begin
      tail_nxt_s = tail_r;
    end
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_nxt_s = count_r + 6'd1;
      2'b01:   count_nxt_s = count_r - 6'd1;
      2'b11:   count_nxt_s = count_r;
      2'b00:   count_nxt_s = count_r;
      default: count_nxt_s = count_r;
    endcase
  end

  // Pointer and occupancy registers; flush returns them to the reset state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head_r  <= 5'd0;
      tail_r  <= 5'd0;
      count_r <= DEPTH;
    end else if (flush_fl) begin
      head_r  <= 5'd0;
      tail_r  <= 5'd0;
      count_r <= DEPTH;
    end else begin
      head_r  <= head_nxt_s;
      tail_r  <= tail_nxt_s;
      count_r <= count_nxt_s;
    end
  end

  // Tag storage: reloaded with the identity image on reset/flush, written at the tail on push.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mem_r <= init_image();
    end else if (flush_fl) begin
      mem_r <= init_image();
    end else if (push_ok_s) begin
      mem_r[tail_r] <= tag_in_fl;
    end else begin
      mem_r <= mem_r;
    end
  end

  // Sticky error flags; only reset clears them, flush leaves them alone.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ovf_r <= 1'b0;
      unf_r <= 1'b0;
    end else begin
      ovf_r <= ovf_r | push_bad_s;
      unf_r <= unf_r | pop_bad_s;
    end
  end

  assign tag_fl       = mem_r[head_r];
  assign tag_valid_fl = ~empty_s;
  assign count_fl     = count_r;
  assign full_fl      = full_s;
  assign empty_fl     = empty_s;
  assign ovf_err_fl   = ovf_r;
  assign unf_err_fl   = unf_r;

endmodule

// File: tb/tb_tag_free_list.sv
// Self-checking bench for tag_free_list against a queue-based free-list model.
module tb_tag_free_list;

  logic       clock;
  logic       reset;
  logic       pop_fl;
  logic [4:0] tag_fl;
  logic       tag_valid_fl;
  logic       push_fl;
  logic [4:0] tag_in_fl;
  logic       flush_fl;
  logic [5:0] count_fl;
  logic       full_fl;
  logic       empty_fl;
  logic       ovf_err_fl;
  logic       unf_err_fl;

  int checks = 0;
  int errors = 0;

  // Reference model: the free tags in FIFO order plus the sticky flags.
  int q[$];
  bit m_ovf;
  bit m_unf;

  tag_free_list dut (
    .clock        (clock),
    .reset        (reset),
    .pop_fl       (pop_fl),
    .tag_fl       (tag_fl),
    .tag_valid_fl (tag_valid_fl),
    .push_fl      (push_fl),
    .tag_in_fl    (tag_in_fl),
    .flush_fl     (flush_fl),
    .count_fl     (count_fl),
    .full_fl      (full_fl),
    .empty_fl     (empty_fl),
    .ovf_err_fl   (ovf_err_fl),
    .unf_err_fl   (unf_err_fl)
  );

  // Free-running clock, period 10.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic model_restore();
    q.delete();
    for (int i = 0; i < 32; i++) q.push_back(i);
  endtask

  task automatic model_reset();
    model_restore();
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  // Apply one clock edge of requests to the model.
  task automatic model_edge(input bit p, input bit u, input logic [4:0] t, input bit f);
    bit was_empty;
    bit was_full;
    if (f) begin
      model_restore();
    end else begin
      was_empty = (q.size() == 0);
      was_full  = (q.size() == 32);
      if (p) begin
        if (was_empty) m_unf = 1'b1;
        else void'(q.pop_front());
      end
      if (u) begin
        if (was_full) m_ovf = 1'b1;
        else q.push_back(int'(t));
      end
    end
  endtask

  // Drive one cycle of requests, advance past the edge and update the model.
  task automatic step(input bit p, input bit u, input logic [4:0] t, input bit f);
    pop_fl    = p;
    push_fl   = u;
    tag_in_fl = t;
    flush_fl  = f;
    @(posedge clock);
    model_edge(p, u, t, f);
    #1;
    pop_fl   = 1'b0;
    push_fl  = 1'b0;
    flush_fl = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    #2;
    model_reset();
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    #12;
    model_reset();
    checks++; if (tag_fl !== 5'd0)      begin errors++; $display("FAIL reset_tag_in: got %0d want 0", tag_fl); end
    checks++; if (count_fl !== 6'd32)   begin errors++; $display("FAIL reset_count_in: got %0d want 32", count_fl); end
    @(negedge clock);
    reset = 1'b1;
    step(1'b0, 1'b0, 5'd0, 1'b0);
    step(1'b0, 1'b0, 5'd0, 1'b0);
    checks++; if (tag_fl !== 5'd0)        begin errors++; $display("FAIL reset_tag: got %0d want 0", tag_fl); end
    checks++; if (count_fl !== 6'd32)     begin errors++; $display("FAIL reset_count: got %0d want 32", count_fl); end
    checks++; if (full_fl !== 1'b1)       begin errors++; $display("FAIL reset_full: got %b want 1", full_fl); end
    checks++; if (tag_valid_fl !== 1'b1)  begin errors++; $display("FAIL reset_valid: got %b want 1", tag_valid_fl); end
    checks++; if (empty_fl !== 1'b0)      begin errors++; $display("FAIL reset_empty: got %b want 0", empty_fl); end
    checks++; if ({ovf_err_fl, unf_err_fl} !== 2'b00) begin errors++; $display("FAIL reset_err: got %b%b want 00", ovf_err_fl, unf_err_fl); end
  endtask

  task automatic test_sequential_pops();
    for (int k = 0; k < 3; k++) begin
      checks++; if (tag_fl !== 5'(k)) begin errors++; $display("FAIL seq_pop_tag%0d: got %0d want %0d", k, tag_fl, k); end
      step(1'b1, 1'b0, 5'd0, 1'b0);
    end
    checks++; if (tag_fl !== 5'd3)    begin errors++; $display("FAIL seq_pop_tag3: got %0d want 3", tag_fl); end
    checks++; if (count_fl !== 6'd29) begin errors++; $display("FAIL seq_pop_count: got %0d want 29", count_fl); end
    checks++; if (full_fl !== 1'b0)   begin errors++; $display("FAIL seq_pop_full: got %b want 0", full_fl); end
  endtask

  task automatic test_drain();
    for (int k = 0; k < 29; k++) begin
      checks++; if (tag_fl !== 5'(q[0])) begin errors++; $display("FAIL drain_tag%0d: got %0d want %0d", k, tag_fl, q[0]); end
      step(1'b1, 1'b0, 5'd0, 1'b0);
    end
    checks++; if (empty_fl !== 1'b1)     begin errors++; $display("FAIL drain_empty: got %b want 1", empty_fl); end
    checks++; if (tag_valid_fl !== 1'b0) begin errors++; $display("FAIL drain_valid: got %b want 0", tag_valid_fl); end
    checks++; if (count_fl !== 6'd0)     begin errors++; $display("FAIL drain_count: got %0d want 0", count_fl); end
    checks++; if (unf_err_fl !== 1'b0)   begin errors++; $display("FAIL drain_unf_early: got %b want 0", unf_err_fl); end
    step(1'b1, 1'b0, 5'd0, 1'b0);
    checks++; if (count_fl !== 6'd0)     begin errors++; $display("FAIL underflow_count: got %0d want 0", count_fl); end
    checks++; if (unf_err_fl !== 1'b1)   begin errors++; $display("FAIL underflow_flag: got %b want 1", unf_err_fl); end
  endtask

  task automatic test_push_empty();
    step(1'b0, 1'b1, 5'd7, 1'b0);
    checks++; if (tag_fl !== 5'd7)   begin errors++; $display("FAIL push_empty_tag: got %0d want 7", tag_fl); end
    checks++; if (count_fl !== 6'd1) begin errors++; $display("FAIL push_empty_count: got %0d want 1", count_fl); end
    step(1'b1, 1'b1, 5'd5, 1'b0);
    checks++; if (tag_fl !== 5'd5)   begin errors++; $display("FAIL push_pop_tag: got %0d want 5", tag_fl); end
    checks++; if (count_fl !== 6'd1) begin errors++; $display("FAIL push_pop_count: got %0d want 1", count_fl); end
    // Push and pop together on an empty list: pop ignored, push lands.
    step(1'b1, 1'b0, 5'd0, 1'b0);
    step(1'b1, 1'b1, 5'd12, 1'b0);
    checks++; if (count_fl !== 6'd1) begin errors++; $display("FAIL empty_simul_count: got %0d want 1", count_fl); end
    checks++; if (tag_fl !== 5'd12)  begin errors++; $display("FAIL empty_simul_tag: got %0d want 12", tag_fl); end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int k = 0; k < 30; k++) step(1'b1, 1'b0, 5'd0, 1'b0);
    for (int k = 0; k < 28; k++) step(1'b0, 1'b1, 5'(k), 1'b0);
    checks++; if (count_fl !== 6'd30) begin errors++; $display("FAIL wrap_pre_count: got %0d want 30", count_fl); end
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 1'b1, 5'(31 - k), 1'b0);
      checks++; if (count_fl !== 6'd30)   begin errors++; $display("FAIL wrap_count%0d: got %0d want 30", k, count_fl); end
      checks++; if (tag_fl !== 5'(q[0]))  begin errors++; $display("FAIL wrap_tag%0d: got %0d want %0d", k, tag_fl, q[0]); end
    end
    // Drain all the way round to confirm FIFO order across the wrap.
    for (int k = 0; k < 30; k++) begin
      checks++; if (tag_fl !== 5'(q[0])) begin errors++; $display("FAIL wrap_order%0d: got %0d want %0d", k, tag_fl, q[0]); end
      step(1'b1, 1'b0, 5'd0, 1'b0);
    end
    for (int k = 0; k < 32; k++) step(1'b0, 1'b1, 5'(k ^ 5), 1'b0);
    checks++; if (full_fl !== 1'b1)   begin errors++; $display("FAIL refill_full: got %b want 1", full_fl); end
    checks++; if (ovf_err_fl !== 1'b0) begin errors++; $display("FAIL refill_ovf_early: got %b want 0", ovf_err_fl); end
    step(1'b0, 1'b1, 5'd9, 1'b0);
    checks++; if (count_fl !== 6'd32) begin errors++; $display("FAIL overflow_count: got %0d want 32", count_fl); end
    checks++; if (ovf_err_fl !== 1'b1) begin errors++; $display("FAIL overflow_flag: got %b want 1", ovf_err_fl); end
    step(1'b1, 1'b1, 5'd9, 1'b0);
    checks++; if (count_fl !== 6'd31) begin errors++; $display("FAIL full_simul_count: got %0d want 31", count_fl); end
    checks++; if (tag_fl !== 5'(q[0])) begin errors++; $display("FAIL full_simul_tag: got %0d want %0d", tag_fl, q[0]); end
  endtask

  task automatic test_random();
    int pop_pct;
    bit p, u, f;
    logic [4:0] t;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      pop_pct = ((c / 60) % 2 == 0) ? 75 : 25;
      p = ($urandom_range(99) < pop_pct);
      u = ($urandom_range(99) < (100 - pop_pct));
      f = ($urandom_range(79) == 0);
      t = 5'($urandom);
      step(p, u, t, f);
      checks++; if (count_fl !== 6'(q.size())) begin errors++; $display("FAIL rnd_count c%0d: got %0d want %0d", c, count_fl, q.size()); end
      checks++; if (full_fl !== (q.size() == 32)) begin errors++; $display("FAIL rnd_full c%0d: got %b", c, full_fl); end
      checks++; if (empty_fl !== (q.size() == 0)) begin errors++; $display("FAIL rnd_empty c%0d: got %b", c, empty_fl); end
      checks++; if (tag_valid_fl !== (q.size() != 0)) begin errors++; $display("FAIL rnd_valid c%0d: got %b", c, tag_valid_fl); end
      checks++; if ({ovf_err_fl, unf_err_fl} !== {m_ovf, m_unf}) begin errors++; $display("FAIL rnd_err c%0d: got %b%b want %b%b", c, ovf_err_fl, unf_err_fl, m_ovf, m_unf); end
      if (q.size() != 0) begin
        checks++; if (tag_fl !== 5'(q[0])) begin errors++; $display("FAIL rnd_tag c%0d: got %0d want %0d", c, tag_fl, q[0]); end
      end
    end
  endtask

  task automatic test_flush();
    do_reset();
    for (int k = 0; k < 10; k++) step(1'b1, 1'b0, 5'd0, 1'b0);
    checks++; if (tag_fl !== 5'd10) begin errors++; $display("FAIL flush_pre_tag: got %0d want 10", tag_fl); end
    step(1'b1, 1'b0, 5'd0, 1'b1);
    checks++; if (count_fl !== 6'd32) begin errors++; $display("FAIL flush_count: got %0d want 32", count_fl); end
    checks++; if (tag_fl !== 5'd0)    begin errors++; $display("FAIL flush_tag: got %0d want 0", tag_fl); end
    checks++; if ({ovf_err_fl, unf_err_fl} !== 2'b00) begin errors++; $display("FAIL flush_err: got %b%b want 00", ovf_err_fl, unf_err_fl); end
    for (int k = 0; k < 33; k++) step(1'b1, 1'b0, 5'd0, 1'b0);
    step(1'b0, 1'b1, 5'd3, 1'b1);
    checks++; if (unf_err_fl !== 1'b1) begin errors++; $display("FAIL flush_keeps_unf: got %b want 1", unf_err_fl); end
    checks++; if (count_fl !== 6'd32)  begin errors++; $display("FAIL flush_push_count: got %0d want 32", count_fl); end
    checks++; if (tag_fl !== 5'd0)     begin errors++; $display("FAIL flush_push_tag: got %0d want 0", tag_fl); end
  endtask

  task automatic test_async_reset();
    for (int k = 0; k < 5; k++) step(1'b1, 1'b0, 5'd0, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    checks++; if (count_fl !== 6'd32) begin errors++; $display("FAIL async_count: got %0d want 32", count_fl); end
    checks++; if (tag_fl !== 5'd0)    begin errors++; $display("FAIL async_tag: got %0d want 0", tag_fl); end
    checks++; if ({ovf_err_fl, unf_err_fl} !== 2'b00) begin errors++; $display("FAIL async_err: got %b%b want 00", ovf_err_fl, unf_err_fl); end
    @(negedge clock);
    reset = 1'b1;
    step(1'b1, 1'b0, 5'd0, 1'b0);
    checks++; if (tag_fl !== 5'd1)    begin errors++; $display("FAIL post_async_tag: got %0d want 1", tag_fl); end
    checks++; if (count_fl !== 6'd31) begin errors++; $display("FAIL post_async_count: got %0d want 31", count_fl); end
  endtask

  initial begin
    reset     = 1'b0;
    pop_fl    = 1'b0;
    push_fl   = 1'b0;
    tag_in_fl = 5'd0;
    flush_fl  = 1'b0;
    m_ovf     = 1'b0;
    m_unf     = 1'b0;
    test_reset();
    test_sequential_pops();
    test_drain();
    test_push_empty();
    test_wrap();
    test_random();
    test_flush();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
